piso_shift_reg: RTL and testbench
=================================

# piso_shift_reg

Parametrised parallel-in/serial-out shift register, the WIDTH-generic successor of the 8-bit 74LS165-style serializer in the logic-family library. A parallel word is accepted through a load handshake, then shifted out one bit per enabled clock, MSB-first or LSB-first per word. The block has a bit counter, a clock inhibit, complementary serial outputs and a word-complete pulse. It sits between a parallel data source and a single-wire serial sink, or in a cascade of serializers.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..64.
- CW, $clog2(WIDTH), bit-counter width; derived, do not override.
- cp  in  1  clock; all state changes on the rising edge.
- mr  in  1  master reset; asynchronous, active-high.
- inh  in  1  clock inhibit, active-high; freezes all state, and blocks load acceptance.
- ld  in  1  load request.
- ld_rdy  out  1  load ready; the load handshake completes on any edge where ld && ld_rdy.
- p  in  WIDTH  parallel data word; captured on handshake.
- msb_first  in  1  shift direction for this word; captured on handshake.
- ds  in  1  serial fill input; shifted into the vacated end of the register.
- out  out  1  serial data output.
- out_  out  1  complement of out; always ~out.
- busy  out  1  high while a word (and its parity bit, if enabled) is being emitted.
- done  out  1  one-cycle pulse; marks completion of a word.

## Operation
- Reset values: sreg=0, dir=1, cnt=0, state=IDLE, out=0, out_=1, busy=0, done=0. ld_rdy=1 once mr is released.
- State machine states: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- out is the output-end bit of sreg: sreg[WIDTH-1] when dir=1, sreg[0] when dir=0. In PARITY, out is the parity bit instead.
- ld_rdy = !inh && (state==IDLE || last), where last is the final emitting cycle.
  - Without the macro, last = SHIFT && cnt==0.
  - With the macro, last = PARITY.
- Handshake:
  - sreg<=p, dir<=msb_first, cnt<=WIDTH-1, state<=SHIFT.
  - With the macro, par<=^p.
- SHIFT, !inh, cnt!=0:
  - Shift sreg one place toward the output end.
  - Fill the vacated end with ds: dir=1 gives {sreg[WIDTH-2:0],ds}; dir=0 gives {ds,sreg[WIDTH-1:1]}.
  - cnt<=cnt-1.
- SHIFT, !inh, cnt==0:
  - Shift once more.
  - With the macro, go to PARITY.
  - Without the macro: a handshake in this cycle loads the next word (back-to-back); otherwise go to IDLE.
- PARITY, !inh: a handshake in this cycle loads the next word; otherwise go to IDLE.
- done is registered. It is 1 in the cycle after the last cycle was clocked with !inh, including when a back-to-back load happens.
- busy = (state!=IDLE).
- IDLE holds sreg; no shifting in IDLE.
- inh=1 in any state: sreg, cnt, state, dir and par hold; done<=0; ld_rdy=0.
- ld while ld_rdy=0: ignored, no effect; the source must hold ld.
- mr mid-word: immediate return to the reset values above; the partial word is discarded and no done is produced.

## Timing
- Handshake at edge N: bit 0 (MSB or LSB per dir) is on out in cycle N+1.
- Bit k is on out in cycle N+1+k, for k=0..WIDTH-1, counting non-inhibited cycles only.
- Parity bit, with the macro: cycle N+1+WIDTH.
- Word period: WIDTH cycles without the macro, WIDTH+1 with it. Back-to-back words have zero gap.
- done is high in cycle N+1+WIDTH (or N+2+WIDTH with the macro), coincident with the next word's first bit when back-to-back.
- out and out_ are registered/state-derived only; no combinational path from ld, p or ds to out.

## Configuration
- PISO_PARITY_EN defined:
  - After each word, one extra cycle emits even parity: the XOR of the captured p.
  - The PARITY state and the par register are present.
- PISO_PARITY_EN undefined:
  - No PARITY state, no par register.
  - The word is exactly WIDTH bits; ld_rdy rises in the final data-bit cycle.

## Test plan
- Reset and load, MSB-first: reset, then load p=8'hA5 with msb_first=1, no inh → out=1,0,1,0,0,1,0,1 in cycles N+1..N+8; done=1 at N+9; busy=0 at N+9.
- LSB-first with fill: load p=8'hA5, msb_first=0, ds=1 → out=1,0,1,0,0,1,0,1 (LSB order); sreg=8'hFF after completion; out_ always ~out.
- Inhibit: load 8'h81, then assert inh for 3 cycles after bit 2 → out frozen for 3 cycles; ld_rdy=0 throughout; no bit lost or duplicated; done delayed by exactly 3 cycles.
- Back-to-back: hold ld=1 with 8'hF0 then 8'h0F → 16 contiguous bits 11110000 00001111; done pulse coincides with the first bit of the second word; no IDLE cycle between words.
- Mid-word reset: assert mr during bit 4 of 8'hFF → out=0, out_=1, busy=0 immediately; no done pulse.
- PISO_PARITY_EN, WIDTH=4: load 4'b1011, msb_first=1 → out=1,0,1,1, then parity 1; ld_rdy=1 only in the parity cycle; done one cycle later.

Source files
------------

// File: rtl/piso_shift_reg_if.sv
// piso_shift_reg_if: load handshake, control and serial output bundle for
// piso_shift_reg.
//   master modport (data source / serial sink side):
//     drives  inh, ld, p, msb_first, ds
//     samples ld_rdy, out, out_, busy, done
//   slave modport (the serializer):
//     samples inh, ld, p, msb_first, ds
//     drives  ld_rdy, out, out_, busy, done
interface piso_shift_reg_if #(
    parameter int WIDTH = 8
);
    logic             inh;
    logic             ld;
    logic             ld_rdy;
    logic [WIDTH-1:0] p;
    logic             msb_first;
    logic             ds;
    logic             out;
    logic             out_;
    logic             busy;
    logic             done;

    modport master (
        output inh, ld, p, msb_first, ds,
        input  ld_rdy, out, out_, busy, done
    );

    modport slave (
        input  inh, ld, p, msb_first, ds,
        output ld_rdy, out, out_, busy, done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// piso_shift_reg: WIDTH-generic parallel-in/serial-out shift register.
// A word is captured on the ld && ld_rdy handshake. It is then shifted out
// one bit per non-inhibited clock, MSB-first or LSB-first as selected for
// that word. Back-to-back loads give gap-free streams.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit
// after each word.
// Ports:
//   cp   clock, rising edge
//   mr   asynchronous active-high master reset
//   bus  piso_shift_reg_if.slave: inh, ld/ld_rdy, p, msb_first, ds in;
//        out/out_, busy, done out
module piso_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic              cp,
    input  logic              mr,
    piso_shift_reg_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
        , PARITY = 2'd2
`endif
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sreg_r;
    logic [CW-1:0]    cnt_r;
    logic             dir_r;
    logic             done_r;
    logic             load_s;
    logic             last_s;
    logic             ld_rdy_s;
    logic             out_s;
`ifdef PISO_PARITY_EN
    logic             par_r;

    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    // State register
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; load_s marks a completed handshake this cycle
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        if (bus.inh) begin
            state_nxt_s = state_r;
        end else begin
            load_s = bus.ld && ld_rdy_s;
            case (state_r)
                IDLE: begin
                    if (load_s) state_nxt_s = SHIFT;
                    else        state_nxt_s = IDLE;
                end
                SHIFT: begin
                    if (cnt_r != {CW{1'b0}}) begin
                        state_nxt_s = SHIFT;
                    end else begin
`ifdef PISO_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        if (load_s) state_nxt_s = SHIFT;
                        else        state_nxt_s = IDLE;
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    if (load_s) state_nxt_s = SHIFT;
                    else        state_nxt_s = IDLE;
                end
`endif
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Output decode: last emitting cycle, load ready and serial bit
    always_comb begin
        last_s = 1'b0;
        out_s  = 1'b0;
`ifdef PISO_PARITY_EN
        last_s = (state_r == PARITY);
`else
        last_s = (state_r == SHIFT) && (cnt_r == {CW{1'b0}});
`endif
        ld_rdy_s = !bus.inh && ((state_r == IDLE) || last_s);
`ifdef PISO_PARITY_EN
        if (state_r == PARITY) begin
            out_s = par_r;
        end else if (dir_r) begin
            out_s = sreg_r[WIDTH-1];
        end else begin
            out_s = sreg_r[0];
        end
`else
        if (dir_r) begin
            out_s = sreg_r[WIDTH-1];
        end else begin
            out_s = sreg_r[0];
        end
`endif
    end

    // Datapath: capture on handshake, shift in SHIFT, done pulse after last
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            sreg_r <= {WIDTH{1'b0}};
            cnt_r  <= {CW{1'b0}};
            dir_r  <= 1'b1;
            done_r <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r  <= 1'b0;
`endif
        end else if (bus.inh) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
            if (load_s) begin
                sreg_r <= bus.p;
                dir_r  <= bus.msb_first;
                cnt_r  <= CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
                par_r  <= even_parity(bus.p);
`endif
            end else if (state_r == SHIFT) begin
                // Shift toward the output end, filling the vacated end with ds
                if (dir_r) sreg_r <= {sreg_r[WIDTH-2:0], bus.ds};
                else       sreg_r <= {bus.ds, sreg_r[WIDTH-1:1]};
                if (cnt_r != {CW{1'b0}}) cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign bus.ld_rdy = ld_rdy_s;
    assign bus.out    = out_s;
    assign bus.out_   = ~out_s;
    assign bus.busy   = (state_r != IDLE);
    assign bus.done   = done_r;

endmodule

// File: tb/tb_piso_shift_reg.sv
// tb_piso_shift_reg: directed and random stimulus for piso_shift_reg.
// The scoreboard queue holds every bit expected on out, in emission order.
// A bit is popped on each non-inhibited clock. An empty queue means idle.
// A queue holding one entry marks the last emitting cycle, which is used to
// model ld_rdy and done.
module tb_piso_shift_reg;
    localparam int W = 8;

    logic cp = 1'b0;
    logic mr = 1'b1;
    piso_shift_reg_if #(.WIDTH(W)) bus ();

    piso_shift_reg #(.WIDTH(W)) dut (.cp(cp), .mr(mr), .bus(bus));

    always #5 cp = ~cp;

    logic exp_q[$];
    logic exp_done = 1'b0;
    logic last_hs  = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [W-1:0] pw, input logic msb);
        for (int k = 0; k < W; k++) exp_q.push_back(msb ? pw[W-1-k] : pw[k]);
`ifdef PISO_PARITY_EN
        exp_q.push_back(^pw);
`endif
    endtask

    // Compare the current cycle, then clock once and advance the model
    task automatic step();
        logic hs, last, rdy, e, ne;
        if (exp_q.size() > 0) begin
            e  = exp_q[0];
            ne = ~e;
            chk("out", bus.out, e);
            chk("out_", bus.out_, ne);
        end
        chk("busy", bus.busy, exp_q.size() != 0);
        chk("done", bus.done, exp_done);
        last = (exp_q.size() == 1);
        rdy  = !bus.inh && (exp_q.size() == 0 || last);
        chk("ld_rdy", bus.ld_rdy, rdy);
        hs = rdy && bus.ld;
        @(posedge cp);
        #1;
        if (!bus.inh) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (hs) push_word(bus.p, bus.msb_first);
        end
        exp_done = !bus.inh && last;
        last_hs  = hs;
    endtask

    initial begin
        bus.inh = 1'b0; bus.ld = 1'b0; bus.p = '0; bus.msb_first = 1'b1; bus.ds = 1'b0;
        repeat (2) @(posedge cp);
        #1;
        chk("rst_out", bus.out, 1'b0);
        chk("rst_out_", bus.out_, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        mr = 1'b0;
        #1;
        chk("rst_ld_rdy", bus.ld_rdy, 1'b1);
        @(posedge cp);
        #1;

        // MSB-first A5, fill 0
        bus.ld = 1'b1; bus.p = 8'hA5; bus.msb_first = 1'b1; bus.ds = 1'b0;
        step();
        bus.ld = 1'b0;
        repeat (W + 3) step();
        chk("idle_out_msb", bus.out, 1'b0);

        // LSB-first A5, fill 1
        bus.ld = 1'b1; bus.p = 8'hA5; bus.msb_first = 1'b0; bus.ds = 1'b1;
        step();
        bus.ld = 1'b0;
        repeat (W + 3) step();
        chk("sreg_fill", dut.sreg_r, {W{1'b1}});
        chk("idle_out_lsb", bus.out, 1'b1);

        // Inhibit for 3 cycles while bit 2 of 81 is on out
        bus.ds = 1'b0;
        bus.ld = 1'b1; bus.p = 8'h81; bus.msb_first = 1'b1;
        step();
        bus.ld = 1'b0;
        repeat (2) step();
        bus.inh = 1'b1;
        repeat (3) step();
        bus.inh = 1'b0;
        repeat (W + 2) step();

        // Back-to-back F0 then 0F with ld held high
        bus.ld = 1'b1; bus.p = 8'hF0; bus.msb_first = 1'b1;
        step();
        bus.p = 8'h0F;
        last_hs = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            step();
            if (last_hs) break;
        end
        chk("b2b_handshake", last_hs, 1'b1);
        bus.ld = 1'b0;
        repeat (W + 3) step();

        // Master reset during bit 4 of FF
        bus.ld = 1'b1; bus.p = 8'hFF; bus.msb_first = 1'b1;
        step();
        bus.ld = 1'b0;
        repeat (4) step();
        mr = 1'b1;
        #1;
        chk("mr_out", bus.out, 1'b0);
        chk("mr_out_", bus.out_, 1'b1);
        chk("mr_busy", bus.busy, 1'b0);
        chk("mr_done", bus.done, 1'b0);
        exp_q.delete();
        exp_done = 1'b0;
        @(negedge cp);
        mr = 1'b0;
        @(posedge cp);
        #1;
        repeat (W + 2) step();

        // Random words with random direction and fill
        for (int i = 0; i < 6; i++) begin
            bus.ld = 1'b1;
            bus.p = W'($urandom);
            bus.msb_first = 1'($urandom_range(0, 1));
            bus.ds = 1'($urandom_range(0, 1));
            step();
            bus.ld = 1'b0;
            repeat ($urandom_range(W + 2, W + 4)) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
